// File: rtl/uart_command_arbiter_if.sv
// Bundle of the two UART requester channels and the accumulator handshake.
// slave: arbiter side; master: requesters/accumulator side.
interface uart_command_arbiter_if;
  logic       ble_req;
  logic       ble_valid;
  logic [7:0] ble_data;
  logic       ble_ready;
  logic       host_req;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;
  logic [7:0] acc_data;
  logic       acc_accumulate;
  logic       acc_ble_side;
  logic       acc_soft_reset;
  logic       acc_done;
  logic       acc_error;
  logic       cmd_valid;
  logic       cmd_source;
  logic       abort;
  logic       busy;

  modport slave (
    input  ble_req, ble_valid, ble_data,
    input  host_req, host_valid, host_data,
    input  acc_done, acc_error,
    output ble_ready, host_ready,
    output acc_data, acc_accumulate, acc_ble_side, acc_soft_reset,
    output cmd_valid, cmd_source, abort, busy
  );

  modport master (
    output ble_req, ble_valid, ble_data,
    output host_req, host_valid, host_data,
    output acc_done, acc_error,
    input  ble_ready, host_ready,
    input  acc_data, acc_accumulate, acc_ble_side, acc_soft_reset,
    input  cmd_valid, cmd_source, abort, busy
  );
endinterface

// File: rtl/uart_command_arbiter.sv
// Grants the shared byte accumulator to the BLE or host UART for one whole command.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: BLE fixed priority).
module uart_command_arbiter #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned WATCHDOG     = 4000
) (
  input logic                   clk,
  input logic                   reset,
  uart_command_arbiter_if.slave bus
);

  localparam int unsigned PcW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned WdW = $clog2(WATCHDOG + 1);
  localparam logic [PcW-1:0] PcLast = PcW'(PULSE_CYCLES - 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWaitByte,
    StDrive,
    StRelease,
    StCheck,
    StRecover
  } state_e;

  state_e         state_q;
  logic           owner_q;
  logic [PcW-1:0] pulse_cnt_q;
  logic [WdW-1:0] wd_q;
  logic           done_seen_low_q;
  logic           ble_ready_q;
  logic           host_ready_q;
  logic [7:0]     acc_data_q;
  logic           acc_accumulate_q;
  logic           acc_ble_side_q;
  logic           acc_soft_reset_q;
  logic           cmd_valid_q;
  logic           cmd_source_q;
  logic           abort_q;
  logic           busy_q;

  logic       pick_ble;
  logic       own_valid;
  logic [7:0] own_data;
  logic       wd_expired;
  logic       any_req;

  assign any_req    = bus.ble_req | bus.host_req;
  assign own_valid  = owner_q ? bus.ble_valid : bus.host_valid;
  assign own_data   = owner_q ? bus.ble_data : bus.host_data;
  // Abort on the clock the counter would reach WATCHDOG.
  assign wd_expired = (wd_q == WdLast);

`ifdef UART_ARB_ROUND_ROBIN_EN
  logic last_ble_q;

  // Reset value "host granted last" gives the first contended grant to BLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ble_q <= 1'b0;
    end else if (state_q == StIdle && any_req) begin
      last_ble_q <= pick_ble;
    end
  end

  assign pick_ble = bus.ble_req & (~bus.host_req | ~last_ble_q);
`else
  assign pick_ble = bus.ble_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      owner_q          <= 1'b0;
      pulse_cnt_q      <= '0;
      wd_q             <= '0;
      done_seen_low_q  <= 1'b0;
      ble_ready_q      <= 1'b0;
      host_ready_q     <= 1'b0;
      acc_data_q       <= 8'h00;
      acc_accumulate_q <= 1'b0;
      acc_ble_side_q   <= 1'b0;
      acc_soft_reset_q <= 1'b0;
      cmd_valid_q      <= 1'b0;
      cmd_source_q     <= 1'b0;
      abort_q          <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      ble_ready_q      <= 1'b0;
      host_ready_q     <= 1'b0;
      cmd_valid_q      <= 1'b0;
      abort_q          <= 1'b0;
      acc_soft_reset_q <= 1'b0;

      if (busy_q && !bus.acc_done) begin
        done_seen_low_q <= 1'b1;
      end
      if (busy_q && state_q != StRecover) begin
        wd_q <= wd_q + WdW'(1);
      end

      if (busy_q && state_q != StRecover && state_q != StGrant && wd_expired) begin
        abort_q          <= 1'b1;
        cmd_source_q     <= owner_q;
        acc_accumulate_q <= 1'b0;
        acc_soft_reset_q <= 1'b1;
        state_q          <= StRecover;
      end else begin
        case (state_q)
          StIdle: begin
            if (any_req) begin
              owner_q        <= pick_ble;
              acc_ble_side_q <= pick_ble;
              busy_q         <= 1'b1;
              state_q        <= StGrant;
            end
          end
          StGrant: begin
            done_seen_low_q <= 1'b0;
            wd_q            <= '0;
            state_q         <= StWaitByte;
          end
          StWaitByte: begin
            if (own_valid) begin
              acc_data_q       <= own_data;
              ble_ready_q      <= owner_q;
              host_ready_q     <= ~owner_q;
              wd_q             <= '0;
              acc_accumulate_q <= 1'b1;
              pulse_cnt_q      <= '0;
              state_q          <= StDrive;
            end
          end
          StDrive: begin
            if (pulse_cnt_q == PcLast) begin
              acc_accumulate_q <= 1'b0;
              pulse_cnt_q      <= '0;
              state_q          <= StRelease;
            end else begin
              pulse_cnt_q <= pulse_cnt_q + PcW'(1);
            end
          end
          StRelease: begin
            if (pulse_cnt_q == PcLast) begin
              pulse_cnt_q <= '0;
              state_q     <= StCheck;
            end else begin
              pulse_cnt_q <= pulse_cnt_q + PcW'(1);
            end
          end
          StCheck: begin
            if (bus.acc_error) begin
              abort_q          <= 1'b1;
              cmd_source_q     <= owner_q;
              acc_soft_reset_q <= 1'b1;
              state_q          <= StRecover;
            end else if (done_seen_low_q && bus.acc_done) begin
              cmd_valid_q  <= 1'b1;
              cmd_source_q <= owner_q;
              busy_q       <= 1'b0;
              state_q      <= StIdle;
            end else begin
              state_q <= StWaitByte;
            end
          end
          StRecover: begin
            busy_q          <= 1'b0;
            wd_q            <= '0;
            done_seen_low_q <= 1'b0;
            state_q         <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.ble_ready      = ble_ready_q;
  assign bus.host_ready     = host_ready_q;
  assign bus.acc_data       = acc_data_q;
  assign bus.acc_accumulate = acc_accumulate_q;
  assign bus.acc_ble_side   = acc_ble_side_q;
  assign bus.acc_soft_reset = acc_soft_reset_q;
  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_source     = cmd_source_q;
  assign bus.abort          = abort_q;
  assign bus.busy           = busy_q;

endmodule

// File: doc/uart_command_arbiter.md
UART_COMMAND_ARBITER -- requirements
Module: uart_command_arbiter

Interface
REQ-001 Parameter PULSE_CYCLES, default 2: clocks `acc_accumulate` is held high per byte, and also clocks it is held low after each byte.
REQ-002 Parameter WATCHDOG, default 4000: clocks without grant progress before a granted command is aborted.
REQ-003 Ports, one per line, SHALL be:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low reset
 ble_req  in  1  BLE requester holds high for a whole command
 ble_valid  in  1  BLE byte available
 ble_data  in  8  BLE byte
 ble_ready  out  1  one-cycle pulse: BLE byte taken
 host_req  in  1  host requester holds high for a whole command
 host_valid  in  1  host byte available
 host_data  in  8  host byte
 host_ready  out  1  one-cycle pulse: host byte taken
 acc_data  out  8  byte to accumulator input_data
 acc_accumulate  out  1  accumulator accumulate strobe
 acc_ble_side  out  1  accumulator ble_side select
 acc_soft_reset  out  1  accumulator soft_reset pulse
 acc_done  in  1  accumulator done
 acc_error  in  1  accumulator error
 cmd_valid  out  1  one-cycle pulse: command completed
 cmd_source  out  1  owner of the completed/aborted command (1=BLE, 0=host)
 abort  out  1  one-cycle pulse: command aborted
 busy  out  1  grant active

Function
REQ-004 States SHALL be IDLE, GRANT, WAIT_BYTE, DRIVE, RELEASE, CHECK, RECOVER.
REQ-005 In IDLE with any req high: latch the owner; set `acc_ble_side` = (owner==BLE); set `busy`=1; go to GRANT.
REQ-006 GRANT SHALL last one clock, clear `done_seen_low`, then go to WAIT_BYTE.
REQ-007 In WAIT_BYTE with the owner's valid=1, the block SHALL:
 - register the owner's data into `acc_data`
 - pulse the owner's ready for exactly one clock
 - go to DRIVE
REQ-008 DRIVE SHALL hold `acc_accumulate`=1 for PULSE_CYCLES clocks; `acc_data` SHALL stay stable throughout.
REQ-009 RELEASE SHALL hold `acc_accumulate`=0 for PULSE_CYCLES clocks, then go to CHECK.
REQ-010 `done_seen_low` SHALL set on any clock with `busy`=1 and `acc_done`=0.
REQ-011 CHECK, one clock, in priority order:
 - `acc_error`=1: `abort` pulse → RECOVER
 - `done_seen_low`=1 and `acc_done`=1: `cmd_valid` pulse, `cmd_source`=owner → IDLE
 - otherwise → WAIT_BYTE
REQ-012 The watchdog counter SHALL clear on GRANT and on each ready pulse, and SHALL increment in every other busy clock.
REQ-013 When the watchdog counter reaches WATCHDOG in any busy state, the block SHALL pulse `abort` and go to RECOVER.
REQ-014 RECOVER SHALL drive `acc_soft_reset`=1 and `acc_accumulate`=0 for one clock, then go to IDLE with `busy`=0.
REQ-015 Dropping the owner's req mid-command SHALL NOT end the grant; only completion, error or watchdog SHALL end it.
REQ-016 The non-owner's ready SHALL stay 0 while a grant is active.
REQ-017 Simultaneous requests in IDLE SHALL resolve per REQ-021/022.
REQ-018 `cmd_valid` and `abort` SHALL never assert in the same clock.
REQ-019 `cmd_source` SHALL hold its value until the next completion or abort.

Reset
REQ-020 While reset=0, all state SHALL be IDLE and all outputs 0, except `acc_done`-independent `cmd_source`=0. Counters and flags SHALL be cleared. Reset mid-command SHALL drop the grant immediately with no `cmd_valid` or `abort`.

Configuration
REQ-021 With macro UART_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the requester not granted last; the first grant after reset SHALL go to BLE.
REQ-022 Without UART_ARB_ROUND_ROBIN_EN, BLE SHALL always win simultaneous requests (fixed priority).

Verification
REQ-023 BLE command 41,42,0D, accumulator model ble_side=1 → three `ble_ready` pulses, each `acc_accumulate` high 2 clocks, then one `cmd_valid` with `cmd_source`=1.
REQ-024 Host command 41,BE,EF, `acc_ble_side`=0 → three `host_ready` pulses, then `cmd_valid` with `cmd_source`=0.
REQ-025 Both reqs high in IDLE, twice in a row, macro defined → grants BLE then host; macro undefined → grants BLE then BLE.
REQ-026 Host sends 41,BE,00 → `acc_error`=1 at CHECK → `abort` pulse, one-clock `acc_soft_reset`, then IDLE.
REQ-027 BLE sends one byte then stops, WATCHDOG=50 → `abort` 50 clocks after the ready pulse; BLE req pending during that time is not served meanwhile.
REQ-028 reset=0 asserted in DRIVE → `acc_accumulate`=0 and `busy`=0 immediately, with no `cmd_valid`.
